// File: rtl/c0_iz_pkg.sv
// Shared constants and types for the C0 PS trace port.
// The entry struct is sized by the top-level parameters, so it is declared in the top module.
package c0_iz_pkg;

  localparam logic TUR_ADRES = 1'b0;
  localparam logic TUR_ERIM  = 1'b1;
  localparam int   KAYIP_W   = 16;

  typedef enum logic [1:0] {
    BOSTA,
    ERIM,
    ADRES
  } ser_durum_t;

  // Number of IO_W-bit beats needed to carry one PS value.
  function automatic int beats_of(input int ps_w, input int io_w);
    return ps_w / io_w;
  endfunction

endpackage

// File: rtl/c0_iz_fifo.sv
// Synchronous trace FIFO. A push while full is accepted only when a pop happens in the same cycle.
module c0_iz_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 16
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         push_i,
  input  logic [W-1:0] veri_i,
  input  logic         pop_i,
  output logic [W-1:0] veri_o,
  output logic         full_o,
  output logic         empty_o
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   sayi;
  logic          do_push, do_pop;

  assign full_o  = (sayi == (AW + 1)'(DEPTH));
  assign empty_o = (sayi == '0);
  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);
  assign veri_o  = mem[rd_ptr];

  // NOTE: storage has no reset; only pointers and count define validity, so resetting the array would just cost logic.
  always_ff @(posedge clk_i) begin
    if (do_push) mem[wr_ptr] <= veri_i;
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      sayi   <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   sayi <= sayi + 1'b1;
        2'b01:   sayi <= sayi - 1'b1;
        default: sayi <= sayi;
      endcase
    end
  end

endmodule

// File: rtl/c0_ps_iz_portu.sv
// Retired-PS trace port: optional run-length compression, FIFO buffering with drop accounting,
// and a serialiser that streams entries as run/address beats onto an IO_W-bit lane.
module c0_ps_iz_portu
  import c0_iz_pkg::*;
#(
  parameter int PS_W       = 32,
  parameter int IO_W       = 8,
  parameter int FIFO_DEPTH = 16,
  parameter int PS_ADIM    = 4
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic               gecerli_i,
  input  logic [PS_W-1:0]    ps_i,
  input  logic               sikistir_i,
  input  logic               bosalt_i,
  input  logic               io_hazir_i,
  output logic               out_gecerli_o,
  output logic               out_ilk_o,
  output logic               out_tur_o,
  output logic [IO_W-1:0]    out_veri_o,
  output logic               tasma_o,
  output logic [KAYIP_W-1:0] kayip_o
);

  localparam int BEATS = beats_of(PS_W, IO_W);
  localparam int KW    = $clog2(BEATS + 1);
  localparam logic [IO_W-1:0] RUN_MAX = '1;

  if ((PS_W % IO_W) != 0) begin : g_chk_genislik
    $error("PS_W must be an integer multiple of IO_W");
  end
  if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_chk_derinlik
    $error("FIFO_DEPTH must be a power of 2 and at least 2");
  end

  typedef struct packed {
    logic [IO_W-1:0] run_cnt;
    logic            has_addr;
    logic [PS_W-1:0] ps;
  } entry_t;

  // ---------------- compressor ----------------
  logic [IO_W-1:0] run, run_nxt;
  logic            adres_gerek, adres_gerek_nxt;
  logic [PS_W-1:0] son_ps;
  logic            onceki_sik;
  logic            flush, push, pop, fifo_dolu, fifo_bos;
  entry_t          push_entry, fifo_out;

  assign flush = bosalt_i || (sikistir_i != onceki_sik);

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    push            = 1'b0;
    push_entry      = '0;
    run_nxt         = run;
    adres_gerek_nxt = adres_gerek;
    if (gecerli_i) begin
      if (!sikistir_i || adres_gerek || flush || (ps_i != son_ps + PS_W'(PS_ADIM))) begin
        push                = 1'b1;
        push_entry.run_cnt  = run;
        push_entry.has_addr = 1'b1;
        push_entry.ps       = ps_i;
        run_nxt             = '0;
        adres_gerek_nxt     = flush;
      end else if (run == RUN_MAX - 1'b1) begin
        push               = 1'b1;
        push_entry.run_cnt = RUN_MAX;
        run_nxt            = '0;
      end else begin
        run_nxt = run + 1'b1;
      end
    end else if (flush) begin
      if (run != '0) begin
        push               = 1'b1;
        push_entry.run_cnt = run;
      end
      run_nxt         = '0;
      adres_gerek_nxt = 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      run         <= '0;
      adres_gerek <= 1'b1;
      son_ps      <= '0;
      onceki_sik  <= 1'b0;
      tasma_o     <= 1'b0;
      kayip_o     <= '0;
    end else begin
      onceki_sik <= sikistir_i;
      if (gecerli_i) son_ps <= ps_i;
      // A dropped entry breaks the stream, so force a fresh address afterwards.
      if (push && fifo_dolu && !pop) begin
        run         <= '0;
        adres_gerek <= 1'b1;
        tasma_o     <= 1'b1;
        if (kayip_o != '1) kayip_o <= kayip_o + 1'b1;
      end else begin
        run         <= run_nxt;
        adres_gerek <= adres_gerek_nxt;
      end
    end
  end

  c0_iz_fifo #(
    .W     ($bits(entry_t)),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .push_i  (push),
    .veri_i  (push_entry),
    .pop_i   (pop),
    .veri_o  (fifo_out),
    .full_o  (fifo_dolu),
    .empty_o (fifo_bos)
  );

  // ---------------- serialiser ----------------
  ser_durum_t      durum, durum_nxt;
  logic [PS_W-1:0] adr_sh, sh_nxt;
  logic [KW-1:0]   kalan, kalan_nxt;
  logic            cur_has_addr, has_addr_nxt;
  logic            gecerli_nxt, ilk_nxt, tur_nxt;
  logic [IO_W-1:0] veri_nxt;
  logic            aktar, son_beat;

  assign aktar    = out_gecerli_o && io_hazir_i;
  assign son_beat = ((durum == ERIM) && !cur_has_addr) || ((durum == ADRES) && (kalan == '0));

  always_comb begin
    durum_nxt    = durum;
    sh_nxt       = adr_sh;
    kalan_nxt    = kalan;
    has_addr_nxt = cur_has_addr;
    gecerli_nxt  = out_gecerli_o;
    ilk_nxt      = out_ilk_o;
    tur_nxt      = out_tur_o;
    veri_nxt     = out_veri_o;
    pop          = 1'b0;
    if ((durum == BOSTA) || (aktar && son_beat)) begin
      if (!fifo_bos) begin
        pop          = 1'b1;
        has_addr_nxt = fifo_out.has_addr;
        gecerli_nxt  = 1'b1;
        ilk_nxt      = 1'b1;
        kalan_nxt    = KW'(BEATS - 1);
        if (fifo_out.run_cnt != '0) begin
          durum_nxt = ERIM;
          tur_nxt   = TUR_ERIM;
          veri_nxt  = fifo_out.run_cnt;
          sh_nxt    = fifo_out.ps;
        end else begin
          durum_nxt = ADRES;
          tur_nxt   = TUR_ADRES;
          veri_nxt  = fifo_out.ps[IO_W-1:0];
          sh_nxt    = fifo_out.ps >> IO_W;
        end
      end else begin
        durum_nxt   = BOSTA;
        gecerli_nxt = 1'b0;
        ilk_nxt     = 1'b0;
        tur_nxt     = 1'b0;
        veri_nxt    = '0;
      end
    end else if (aktar) begin
      // Leaving a run beat opens the address group, so that beat is still a first beat.
      ilk_nxt   = (durum == ERIM);
      tur_nxt   = TUR_ADRES;
      veri_nxt  = adr_sh[IO_W-1:0];
      sh_nxt    = adr_sh >> IO_W;
      durum_nxt = ADRES;
      if (durum == ADRES) kalan_nxt = kalan - 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      durum         <= BOSTA;
      adr_sh        <= '0;
      kalan         <= '0;
      cur_has_addr  <= 1'b0;
      out_gecerli_o <= 1'b0;
      out_ilk_o     <= 1'b0;
      out_tur_o     <= 1'b0;
      out_veri_o    <= '0;
    end else begin
      durum         <= durum_nxt;
      adr_sh        <= sh_nxt;
      kalan         <= kalan_nxt;
      cur_has_addr  <= has_addr_nxt;
      out_gecerli_o <= gecerli_nxt;
      out_ilk_o     <= ilk_nxt;
      out_tur_o     <= tur_nxt;
      out_veri_o    <= veri_nxt;
    end
  end

endmodule
